sobol_gen_1d: RTL and testbench

- Gray-code (Antonov–Saleev) Sobol sequence generator for one dimension.
- Produces a run of quasi-random u values in [0,1), fixed point, through a valid/ready stream.
- Sits directly upstream of the inverse-CDF normal stage; u_out/valid_out/ready_in connect to its u_in/valid_in/ready_out.
- Direction numbers sit in a small writable table. Reset contents give the van der Corput sequence (dimension 1).
- Optional digital-shift scramble.

---
 rtl/sobol_gen_1d.sv | 149 ++++++++++++++
 tb/tb_sobol_gen_1d.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobol_gen_1d.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sobol_gen_1d : Gray-code (Antonov-Saleev) 1-D Sobol generator, u in [0,1) |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module sobol_gen_1d #(
    parameter int WIDTH      = 32,
    parameter int QFRAC      = 16,
    parameter int SOBOL_BITS = 32,
    parameter int SKIP_ZERO  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [31:0]                   num_points,
    input  logic [SOBOL_BITS-1:0]         shift_seed,
    input  logic                          dir_we,
    input  logic [$clog2(SOBOL_BITS)-1:0] dir_addr,
    input  logic [SOBOL_BITS-1:0]         dir_data,
    output logic                          busy,
    output logic                          done,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic [WIDTH-1:0]              u_out
);

    localparam int AW = $clog2(SOBOL_BITS);
    localparam int CW = $clog2(SOBOL_BITS + 1);
    localparam logic [CW-1:0] C_DEPTH   = CW'(SOBOL_BITS);
    localparam logic [AW:0]   C_DEPTH_A = (AW + 1)'(SOBOL_BITS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_next;

    logic [SOBOL_BITS-1:0] r_dir [SOBOL_BITS];
    logic [SOBOL_BITS-1:0] r_x;
    logic [SOBOL_BITS-1:0] r_seed;
    logic [SOBOL_BITS-1:0] r_n;
    logic [31:0]           r_total;
    logic [31:0]           r_count;

    logic                  w_start_ok;
    logic                  w_xfer;
    logic                  w_last;
    logic                  w_dir_wr;
    logic [SOBOL_BITS-1:0] w_v0;
    logic [CW-1:0]         w_ones;
    logic                  w_stop;
    logic [SOBOL_BITS-1:0] w_step;

    assign w_start_ok = start && (r_state == ST_IDLE);
    assign w_xfer     = (r_state == ST_RUN) && ready_in;
    assign w_last     = w_xfer && (r_count == (r_total - 32'd1));
    assign w_dir_wr   = dir_we && (r_state == ST_IDLE) && ({1'b0, dir_addr} < C_DEPTH_A);

    // A table write in the start cycle must be visible to the first point.
    assign w_v0 = (w_dir_wr && (dir_addr == '0)) ? dir_data : r_dir[0];

    // Trailing-ones count of n selects which direction number flips next.
    always_comb begin
        w_ones = '0;
        w_stop = 1'b0;
        for (int k = 0; k < SOBOL_BITS; k++) begin
            if (!w_stop) begin
                if (r_n[k]) begin
                    w_ones = CW'(k + 1);
                end else begin
                    w_stop = 1'b1;
                end
            end
        end
    end

    assign w_step = (w_ones < C_DEPTH) ? r_dir[w_ones[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (num_points == 32'd0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next = ST_FIN;
                end
            end
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != ST_IDLE);
        done      = (r_state == ST_FIN);
        valid_out = (r_state == ST_RUN);
        u_out     = WIDTH'((r_x ^ r_seed) >> (SOBOL_BITS - QFRAC));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_seed  <= '0;
            r_n     <= '0;
            r_total <= '0;
            r_count <= '0;
            for (int k = 0; k < SOBOL_BITS; k++) begin
                r_dir[k] <= SOBOL_BITS'(1) << (SOBOL_BITS - 1 - k);
            end
        end else begin
            if (w_dir_wr) begin
                r_dir[dir_addr] <= dir_data;
            end
            if (w_start_ok) begin
                r_total <= num_points;
                r_seed  <= shift_seed;
                r_count <= '0;
                if (num_points != 32'd0) begin
                    if (SKIP_ZERO != 0) begin
                        r_x <= w_v0;
                        r_n <= SOBOL_BITS'(1);
                    end else begin
                        r_x <= '0;
                        r_n <= '0;
                    end
                end
            end else if (w_xfer) begin
                r_x     <= r_x ^ w_step;
                r_n     <= r_n + SOBOL_BITS'(1);
                r_count <= r_count + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sobol_gen_1d.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sobol_gen_1d : self-checking bench for sobol_gen_1d                   |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_sobol_gen_1d;

    localparam int WIDTH = 32;
    localparam int QFRAC = 16;
    localparam int SB    = 32;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [31:0]      num_points;
    logic [SB-1:0]    shift_seed;
    logic             dir_we;
    logic [AW-1:0]    dir_addr;
    logic [SB-1:0]    dir_data;
    logic             busy;
    logic             done;
    logic             valid_out;
    logic             ready_in;
    logic [WIDTH-1:0] u_out;

    always #5 clk = ~clk;

    sobol_gen_1d #(
        .WIDTH      (WIDTH),
        .QFRAC      (QFRAC),
        .SOBOL_BITS (SB),
        .SKIP_ZERO  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_points (num_points),
        .shift_seed (shift_seed),
        .dir_we     (dir_we),
        .dir_addr   (dir_addr),
        .dir_data   (dir_data),
        .busy       (busy),
        .done       (done),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .u_out      (u_out)
    );

    typedef struct {
        logic [31:0] n;
        logic [31:0] seed;
        int          mode;
        logic [15:0] first;
        logic [15:0] last;
    } vec_t;

    int               checks = 0;
    int               errors = 0;
    logic [SB-1:0]    mv [SB];
    logic [WIDTH-1:0] got [$];
    int               done_cnt;
    int               busy_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < SB; k++) mv[k] = 32'h8000_0000 >> k;
    endfunction

    // Point idx of the sequence is the XOR of v[k] over the set bits of gray(idx).
    function automatic logic [WIDTH-1:0] ref_u(input logic [31:0] idx, input logic [SB-1:0] seed);
        logic [31:0]   g;
        logic [SB-1:0] x;
        g = idx ^ (idx >> 1);
        x = '0;
        for (int k = 0; k < 32; k++) if (g[k]) x = x ^ mv[k];
        x = x ^ seed;
        return WIDTH'(x >> (SB - QFRAC));
    endfunction

    function automatic logic next_ready(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; dir_we = 1'b0; ready_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic write_dir(input logic [AW-1:0] a, input logic [SB-1:0] d);
        @(negedge clk);
        dir_we = 1'b1; dir_addr = a; dir_data = d;
        mv[a] = d;
        @(negedge clk);
        dir_we = 1'b0;
    endtask

    task automatic run(input logic [31:0] n, input logic [SB-1:0] seed, input int mode,
                       input bit wr_busy, input bit wr_start, input logic [SB-1:0] wr_val);
        int cyc;
        got.delete();
        done_cnt = 0;
        busy_cyc = 0;
        @(negedge clk);
        start = 1'b1; num_points = n; shift_seed = seed; ready_in = 1'b1;
        if (wr_start) begin
            dir_we = 1'b1; dir_addr = '0; dir_data = wr_val;
            mv[0] = wr_val;
        end
        @(negedge clk);
        start = 1'b0; dir_we = 1'b0;
        if (n != 0) check("first_valid_latency", {63'd0, valid_out}, 64'd1);
        cyc = 0;
        while (1) begin
            if (cyc >= 2000) begin
                checks++; errors++;
                $display("FAIL run_timeout: got busy=%0b expected busy=0 within 2000 cycles", busy);
                break;
            end
            ready_in = next_ready(mode, cyc);
            if (wr_busy && cyc == 1) begin
                dir_we = 1'b1; dir_addr = '0; dir_data = 32'h1234_5678;
            end else begin
                dir_we = 1'b0;
            end
            if (busy) busy_cyc++;
            if (done) done_cnt++;
            if (valid_out) begin
                check("sample", {32'd0, u_out}, {32'd0, ref_u(32'(got.size() + 1), seed)});
                if (ready_in) got.push_back(u_out);
            end
            if (!busy) break;
            @(negedge clk);
            cyc++;
        end
        dir_we = 1'b0;
        ready_in = 1'b0;
        check("num_samples", 64'(got.size()), {32'd0, n});
        check("done_pulses", 64'(done_cnt), 64'd1);
        if (mode == 0) check("busy_cycles", 64'(busy_cyc), {32'd0, n} + 64'd1);
    endtask

    vec_t             vecs [5];
    logic [15:0]      exp7 [7];

    initial begin
        rst = 1'b1; start = 1'b0; num_points = '0; shift_seed = '0;
        dir_we = 1'b0; dir_addr = '0; dir_data = '0; ready_in = 1'b0;
        model_reset();

        vecs[0] = '{32'd7, 32'h0000_0000, 0, 16'h8000, 16'h2000};
        vecs[1] = '{32'd7, 32'h0000_0000, 1, 16'h8000, 16'h2000};
        vecs[2] = '{32'd2, 32'h4000_0000, 0, 16'hC000, 16'h8000};
        vecs[3] = '{32'd1, 32'h0000_0000, 0, 16'h8000, 16'h8000};
        vecs[4] = '{32'd3, 32'h0000_0000, 2, 16'h8000, 16'h4000};
        exp7 = '{16'h8000, 16'hC000, 16'h4000, 16'h6000, 16'hE000, 16'hA000, 16'h2000};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_busy",  {63'd0, busy},      64'd0);
        check("reset_done",  {63'd0, done},      64'd0);
        check("reset_valid", {63'd0, valid_out}, 64'd0);
        check("reset_u",     {32'd0, u_out},     64'd0);

        for (int i = 0; i < 5; i++) begin
            run(vecs[i].n, vecs[i].seed, vecs[i].mode, 1'b0, 1'b0, '0);
            if (got.size() > 0) begin
                check("vec_first", {32'd0, got[0]}, {48'd0, vecs[i].first});
                check("vec_last",  {32'd0, got[got.size()-1]}, {48'd0, vecs[i].last});
            end
            if (vecs[i].n == 7 && got.size() == 7) begin
                for (int j = 0; j < 7; j++) check("vdc_order", {32'd0, got[j]}, {48'd0, exp7[j]});
            end
        end

        run(32'd0, '0, 0, 1'b0, 1'b0, '0);
        check("zero_run_busy", 64'(busy_cyc), 64'd1);

        write_dir('0, 32'hC000_0000);
        run(32'd1, '0, 0, 1'b0, 1'b0, '0);
        if (got.size() > 0) check("table_write", {32'd0, got[0]}, 64'hC000);

        run(32'd3, '0, 0, 1'b1, 1'b0, '0);
        run(32'd1, '0, 0, 1'b0, 1'b0, '0);
        if (got.size() > 0) check("busy_write_ignored", {32'd0, got[0]}, 64'hC000);

        run(32'd1, '0, 0, 1'b0, 1'b1, 32'hA000_0000);
        if (got.size() > 0) check("write_with_start", {32'd0, got[0]}, 64'hA000);

        do_reset();
        @(negedge clk);
        start = 1'b1; num_points = 32'd7; shift_seed = '0; ready_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid_first", {32'd0, u_out}, 64'h8000);
        @(negedge clk);
        check("mid_valid_before", {63'd0, valid_out}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid", {63'd0, valid_out}, 64'd0);
        check("abort_busy",  {63'd0, busy},      64'd0);
        check("abort_done",  {63'd0, done},      64'd0);
        rst = 1'b0; ready_in = 1'b0;
        model_reset();
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("abort_no_done", {63'd0, done}, 64'd0);
        end
        run(32'd1, '0, 0, 1'b0, 1'b0, '0);
        if (got.size() > 0) check("restart_first", {32'd0, got[0]}, 64'h8000);

        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 1) == 1) write_dir(AW'($urandom_range(0, SB - 1)), $urandom);
            run(32'($urandom_range(1, 40)), $urandom, 2, 1'b0, 1'b0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
